// File: rtl/rx_matched_filter_decim_if.sv
// Sample, result and coefficient-load bundle for the matched filter.
// The master side drives samples/coefficients; the slave side is the filter.
interface rx_matched_filter_decim_if #(
    parameter int N_TAPS      = 33,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int CHANNELS    = 2
);
    localparam int AW = $clog2(N_TAPS);

    logic                           in_valid;
    logic                           in_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data;
    logic                           coef_wr;
    logic [AW-1:0]                  coef_addr;
    logic [COEFF_WIDTH-1:0]         coef_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output coef_wr,
        output coef_addr,
        output coef_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  coef_wr,
        input  coef_addr,
        input  coef_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/rx_matched_filter_decim.sv
// Multi-channel RRC matched filter with decimation.
// One serial MAC per channel; coefficients are shared and loadable at run time.
module rx_matched_filter_decim #(
    parameter int N_TAPS      = 33,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int FRAC_BITS   = 13,
    parameter int DECIM       = 4,
    parameter int CHANNELS    = 2
) (
    input logic                      clk,
    input logic                      reset,
    rx_matched_filter_decim_if.slave bus
);
    localparam int AW    = $clog2(N_TAPS);
    localparam int PW    = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W = PW + AW;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [AW-1:0]   TAP_LAST = AW'(N_TAPS - 1);

    localparam logic signed [ACC_W:0] RND =
        (ACC_W + 1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND,
        OUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PH_W-1:0] phase_q;
    logic [AW-1:0]   tap_q;

    logic signed [DATA_WIDTH-1:0]  taps [CHANNELS][N_TAPS];
    logic signed [COEFF_WIDTH-1:0] coef [N_TAPS];
    logic signed [ACC_W-1:0]       acc  [CHANNELS];
    logic signed [PW-1:0]          prod [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  res  [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  out_q [CHANNELS];

    logic accept;
    logic trigger;
    logic coef_we;

    assign accept  = bus.in_valid && (state_q == IDLE);
    assign trigger = accept && (phase_q == PH_LAST);
    assign coef_we = bus.coef_wr && (state_q == IDLE) &&
                     (32'(bus.coef_addr) < 32'(N_TAPS));

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);

    function automatic logic signed [DATA_WIDTH-1:0] sat_round(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W:0]        r;
        logic signed [DATA_WIDTH-1:0] y;
        r = ((ACC_W + 1)'(a) + RND) >>> FRAC_BITS;
        y = r[DATA_WIDTH-1:0];
        if (r > MAXV) begin
            y = MAXV[DATA_WIDTH-1:0];
        end else if (r < MINV) begin
            y = MINV[DATA_WIDTH-1:0];
        end
        return y;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (tap_q == TAP_LAST) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    taps[c][k] <= '0;
                end
            end
        end else if (accept) begin
            phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                taps[c][0] <= bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k < N_TAPS; k++) begin
                    taps[c][k] <= taps[c][k-1];
                end
            end
        end
    end

    // Writes land on the trigger edge too, so MAC always sees them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                coef[k] <= '0;
            end
        end else if (coef_we) begin
            coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            prod[c] = PW'(taps[c][tap_q]) * PW'(coef[tap_q]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        tap_q <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            acc[c] <= '0;
                        end
                    end
                end
                MAC: begin
                    tap_q <= (tap_q == TAP_LAST) ? '0 : tap_q + AW'(1);
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc[c] <= acc[c] + ACC_W'(prod[c]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            res[c] = sat_round(acc[c]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_q[c] <= '0;
            end
        end else if (state_q == ROUND) begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_q[c] <= res[c];
            end
        end
    end

    for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_out
        assign bus.out_data[gc*DATA_WIDTH +: DATA_WIDTH] = out_q[gc];
    end
endmodule

// File: tb/tb_rx_matched_filter_decim.sv
// Bench for rx_matched_filter_decim: behavioural FIR model feeds a
// scoreboard of expected outputs, plus directed latency/backpressure checks.
module tb_rx_matched_filter_decim;
    localparam int N_TAPS = 33;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int FB     = 13;
    localparam int DECIM  = 4;
    localparam int CH     = 2;
    localparam int AW     = $clog2(N_TAPS);

    typedef struct {
        longint c0;
        longint c1;
    } pair_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   prev_ov = 1'b0;

    pair_t  exp_q [$];
    pair_t  got_q [$];
    int     lat_q [$];
    longint m_tap  [CH][N_TAPS];
    longint m_coef [N_TAPS];
    int     m_phase;

    rx_matched_filter_decim_if #(
        .N_TAPS(N_TAPS), .DATA_WIDTH(DW),
        .COEFF_WIDTH(CW), .CHANNELS(CH)
    ) bus ();

    rx_matched_filter_decim #(
        .N_TAPS(N_TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW),
        .FRAC_BITS(FB), .DECIM(DECIM), .CHANNELS(CH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint fir(input int c);
        longint s = 0;
        for (int k = 0; k < N_TAPS; k++) s += m_tap[c][k] * m_coef[k];
        s = (s + (longint'(1) <<< (FB - 1))) >>> FB;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < N_TAPS; k++) m_tap[c][k] = 0;
        for (int k = 0; k < N_TAPS; k++) m_coef[k] = 0;
        m_phase = 0;
        exp_q.delete();
        lat_q.delete();
        got_q.delete();
    endfunction

    function automatic void model_accept(input longint s0, input longint s1,
                                         input int t);
        pair_t e;
        for (int c = 0; c < CH; c++)
            for (int k = N_TAPS - 1; k > 0; k--) m_tap[c][k] = m_tap[c][k-1];
        m_tap[0][0] = s0;
        m_tap[1][0] = s1;
        if (m_phase == DECIM - 1) begin
            m_phase = 0;
            e.c0 = fir(0);
            e.c1 = fir(1);
            exp_q.push_back(e);
            lat_q.push_back(t);
        end else begin
            m_phase++;
        end
    endfunction

    always @(negedge clk) begin : mon
        pair_t e;
        pair_t g;
        if (bus.out_valid && !prev_ov) begin
            if (lat_q.size() == 0) check("latency_unexpected", 1, 0);
            else check("latency", cyc - lat_q.pop_front(), N_TAPS + 1);
        end
        prev_ov = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            g.c0 = sx(bus.out_data[DW-1:0]);
            g.c1 = sx(bus.out_data[2*DW-1:DW]);
            got_q.push_back(g);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_ch0", g.c0, e.c0);
                check("out_ch1", g.c1, e.c1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint s0, input longint s1);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = {DW'(s1), DW'(s0)};
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
        else model_accept(s0, s1, cyc + 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input longint val, input bit apply);
        bus.coef_wr   = 1'b1;
        bus.coef_addr = AW'(addr);
        bus.coef_data = CW'(val);
        if (apply && addr < N_TAPS) m_coef[addr] = val;
        tick();
        bus.coef_wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 1000) begin
            tick();
            n++;
        end
        check("drain_done", longint'(n < 1000), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_data", longint'(bus.out_data), 0);
    endtask

    longint exp1 [7] = '{0, 0, 0, 0, 400, 800, 1200};

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.coef_wr   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        model_reset();
        tick();
        do_reset();

        // delay line, dropped MAC-time write, out-of-range address
        wr_coef(40, 1234, 1'b0);
        wr_coef(16, 8192, 1'b1);
        for (int n = 1; n <= 28; n++) begin
            send(100 * n, 0);
            if (n == 24) wr_coef(16, 0, 1'b0);
        end
        drain();
        check("s1_count", got_q.size(), 7);
        for (int i = 0; i < 7 && i < got_q.size(); i++)
            check("s1_value", got_q[i].c0, exp1[i]);

        // saturation both ways
        do_reset();
        for (int k = 0; k < N_TAPS; k++) wr_coef(k, 8192, 1'b1);
        for (int i = 0; i < 12; i++) send(32767, 0);
        drain();
        check("sat_pos", got_q[$].c0, 32767);
        check("sat_ch1", got_q[$].c1, 0);
        for (int i = 0; i < 36; i++) send(-32768, 0);
        drain();
        check("sat_neg", got_q[$].c0, -32768);

        // rounding, then backpressure on the next output
        do_reset();
        wr_coef(0, 4096, 1'b1);
        for (int i = 0; i < 4; i++) send(3, 1);
        drain();
        check("rnd_pos_ch0", got_q[$].c0, 2);
        check("rnd_ch1", got_q[$].c1, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(-3, 1);
        begin
            int n = 0;
            logic [CH*DW-1:0] snap;
            while (!bus.out_valid && n < 100) begin
                tick();
                n++;
            end
            check("bp_out_valid_seen", bus.out_valid, 1);
            snap = bus.out_data;
            for (int i = 0; i < 10; i++) begin
                tick();
                check("bp_valid_hold", bus.out_valid, 1);
                check("bp_data_hold", longint'(bus.out_data), longint'(snap));
                check("bp_in_ready_low", bus.in_ready, 0);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_in_ready_back", bus.in_ready, 1);
        check("bp_out_valid_low", bus.out_valid, 0);
        check("rnd_neg_ch0", got_q[$].c0, -1);

        // reset in the middle of MAC clears line, phase and coefficients
        wr_coef(16, 8192, 1'b1);
        for (int i = 0; i < 20; i++) send(500, 7);
        tick();
        tick();
        tick();
        check("mid_mac_busy", bus.in_ready, 0);
        do_reset();
        wr_coef(16, 8192, 1'b1);
        for (int n = 1; n <= 8; n++) send(100 * n, 0);
        drain();
        check("post_rst_count", got_q.size(), 2);
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            check("post_rst_ch0", got_q[i].c0, 0);
            check("post_rst_ch1", got_q[i].c1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
